// File: rtl/sim_run_pkg.sv
// Shared types for the simulation run supervisor.
//   run_state_t : supervisor states (reset hold, run, error drain, terminal done)
//   fail_code_t : terminal failure reason reported on fail_code
package sim_run_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_MON     = 3'd1,
    FC_MEM     = 3'd2,
    FC_TIMEOUT = 3'd3,
    FC_STALL   = 3'd4
  } fail_code_t;

endpackage

// File: rtl/sim_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : clock
//   rst     : synchronous active-low reset (0 = reset)
//   i_clr   : clear to zero (wins over increment)
//   i_inc   : increment by one, holding at all-ones
//   o_count : registered count
module sim_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sim_run_controller.sv
// Run supervisor for the simulation top: sequences DUT reset, watches halt /
// commit strobes and error flags, enforces global and no-progress timeouts,
// and reports one terminal verdict.
//   clk, rst        : clock, synchronous active-low reset
//   halt_mode       : 0 = any channel halting passes, 1 = all channels (sticky)
//   halt, commit    : per-channel halt strobe and commit valid
//   mon_error       : monitor error flag
//   mem_error       : memory model error flag
//   dut_rst         : active-high reset to DUT and memory model
//   running         : high while in RUN
//   done            : sticky terminal verdict valid
//   pass, fail_code : verdict (valid when done)
//   cycle_count     : RUN cycles elapsed, saturating
module sim_run_controller
  import sim_run_pkg::*;
#(
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned STALL_CYCLES   = 100000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt_mode,
  input  logic [CHANNELS-1:0] halt,
  input  logic [CHANNELS-1:0] commit,
  input  logic                mon_error,
  input  logic                mem_error,
  output logic                dut_rst,
  output logic                running,
  output logic                done,
  output logic                pass,
  output logic [2:0]          fail_code,
  output logic [CNT_W-1:0]    cycle_count
);

  // RESET_CYCLES=0 and DRAIN_CYCLES=0 both collapse to a single cycle.
  localparam int unsigned RST_LAST   = (RESET_CYCLES == 0) ? 0 : RESET_CYCLES - 1;
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  // Limits compared against count+1 one bit wider so a saturated count cannot wrap.
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0] STALL_LIM   = (CNT_W+1)'(STALL_CYCLES);

  run_state_t          r_state;
  logic                r_dut_rst;
  logic                r_running;
  logic                r_done;
  logic                r_pass;
  fail_code_t          r_fail_code;
  logic [CHANNELS-1:0] r_halted_mask;

  logic [CNT_W-1:0]    w_cycle_cnt;
  logic [CNT_W-1:0]    w_stall_cnt;
  logic [CNT_W-1:0]    w_rst_cnt;
  logic [CNT_W-1:0]    w_drain_cnt;
  logic                w_in_run;
  logic                w_any_commit;
  logic                w_halt_ok;
  logic                w_timeout;
  logic                w_stall;
  logic [CNT_W:0]      w_cycle_p1;
  logic [CNT_W:0]      w_stall_p1;

  assign w_in_run     = (r_state == RUN);
  assign w_any_commit = |commit;

  // Counters: cycle and stall advance only in RUN; drain count restarts on every
  // RUN cycle so it is zero on entry to DRAIN.
  sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .i_clr(1'b0), .i_inc(w_in_run), .o_count(w_cycle_cnt)
  );

  sim_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .i_clr(w_in_run && w_any_commit),
    .i_inc(w_in_run && !w_any_commit), .o_count(w_stall_cnt)
  );

  sim_sat_counter #(.W(CNT_W)) u_rst_cnt (
    .clk(clk), .rst(rst), .i_clr(1'b0), .i_inc(r_state == RESET_HOLD),
    .o_count(w_rst_cnt)
  );

  sim_sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clk(clk), .rst(rst), .i_clr(w_in_run), .i_inc(r_state == DRAIN),
    .o_count(w_drain_cnt)
  );

  // RUN-cycle evaluation terms.
  assign w_cycle_p1 = (CNT_W+1)'(w_cycle_cnt) + (CNT_W+1)'(1);
  assign w_stall_p1 = (CNT_W+1)'(w_stall_cnt) + (CNT_W+1)'(1);
  assign w_halt_ok  = halt_mode ? (&(r_halted_mask | halt)) : (|halt);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cycle_p1 >= TIMEOUT_LIM);
  assign w_stall    = (STALL_CYCLES != 0) && (w_stall_p1 >= STALL_LIM);

  // Supervisor FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= RESET_HOLD;
      r_dut_rst     <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail_code   <= FC_NONE;
      r_halted_mask <= '0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          r_dut_rst <= 1'b1;
          if (w_rst_cnt == CNT_W'(RST_LAST)) begin
            r_state   <= RUN;
            r_dut_rst <= 1'b0;
            r_running <= 1'b1;
          end
        end

        RUN: begin
          r_halted_mask <= r_halted_mask | halt;
          // Errors outrank halt; halt outranks the timeouts.
          if (mon_error) begin
            r_state     <= DRAIN;
            r_running   <= 1'b0;
            r_fail_code <= FC_MON;
          end else if (mem_error) begin
            r_state     <= DRAIN;
            r_running   <= 1'b0;
            r_fail_code <= FC_MEM;
          end else if (w_halt_ok) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b1;
          end else if (w_timeout) begin
            r_state     <= DONE;
            r_running   <= 1'b0;
            r_done      <= 1'b1;
            r_fail_code <= FC_TIMEOUT;
          end else if (w_stall) begin
            r_state     <= DONE;
            r_running   <= 1'b0;
            r_done      <= 1'b1;
            r_fail_code <= FC_STALL;
          end
        end

        DRAIN: begin
          // Hold off the fail verdict so the waveform captures the aftermath.
          if (w_drain_cnt >= CNT_W'(DRAIN_LAST)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          r_state <= DONE;
        end

        default: begin
          r_state <= RESET_HOLD;
        end
      endcase
    end
  end

  assign dut_rst     = r_dut_rst;
  assign running     = r_running;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail_code   = r_fail_code;
  assign cycle_count = w_cycle_cnt;

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed scenario table, hand-written reset
// sequences, and random runs scored against a verdict model.
module tb_sim_run_controller;

  localparam int CH      = 8;
  localparam int RST_CYC = 2;
  localparam int TO_CYC  = 100;
  localparam int ST_CYC  = 16;
  localparam int DR_CYC  = 5;
  localparam int CW      = 32;
  localparam int N       = 112;
  localparam int NV      = 12;

  logic          clk;
  logic          rst;
  logic          halt_mode;
  logic [CH-1:0] halt;
  logic [CH-1:0] commit;
  logic          mon_error;
  logic          mem_error;
  logic          dut_rst;
  logic          running;
  logic          done;
  logic          pass;
  logic [2:0]    fail_code;
  logic [CW-1:0] cycle_count;

  sim_run_controller #(
    .CHANNELS(CH), .RESET_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TO_CYC),
    .STALL_CYCLES(ST_CYC), .DRAIN_CYCLES(DR_CYC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .halt_mode(halt_mode), .halt(halt), .commit(commit),
    .mon_error(mon_error), .mem_error(mem_error), .dut_rst(dut_rst),
    .running(running), .done(done), .pass(pass), .fail_code(fail_code),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    int         h1_at;
    logic [7:0] h1_mask;
    int         h2_at;
    logic [7:0] h2_mask;
    int         mon_at;
    int         mem_at;
    int         commit_last;
    int         exit_step;
    int         done_step;
    logic       exp_pass;
    logic [2:0] exp_code;
  } vec_t;

  vec_t       vecs[NV];
  logic [7:0] st_h[N];
  logic [7:0] st_c[N];
  logic       st_mon[N];
  logic       st_mem[N];
  logic       st_mode;
  int         n_cmp;
  int         n_mis;
  int         cur_case;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s [case %0d] t=%0t: got %0h, expected %0h", nm, cur_case, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    halt_mode = 1'b0; halt = '0; commit = '0; mon_error = 1'b0; mem_error = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_dut_rst", 64'(dut_rst), 64'd1);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail_code", 64'(fail_code), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
  endtask

  // Three cycles of reset, then release and watch the dut_rst pulse.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step(); step(); step();
    chk_reset_vals();
    rst = 1'b1;
    step();
    chk("hold1_dut_rst", 64'(dut_rst), 64'd1);
    chk("hold1_running", 64'(running), 64'd0);
    step();
    chk("run0_dut_rst", 64'(dut_rst), 64'd0);
    chk("run0_running", 64'(running), 64'd1);
    chk("run0_cycle_count", 64'(cycle_count), 64'd0);
  endtask

  task automatic fill_from_vec(input vec_t v);
    st_mode = v.mode;
    for (int k = 0; k < N; k++) begin
      st_h[k]   = ((k == v.h1_at) ? v.h1_mask : 8'h00) | ((k == v.h2_at) ? v.h2_mask : 8'h00);
      st_c[k]   = (k <= v.commit_last) ? 8'hFF : 8'h00;
      st_mon[k] = (k == v.mon_at);
      st_mem[k] = (k == v.mem_at);
    end
  endtask

  // Verdict model: walk the RUN cycles k (cycle_count == k) and find the first
  // decisive cycle by the priority rules; RUN exits on edge k+1.
  task automatic model(output int ex, output int dn, output logic p, output logic [2:0] c);
    int         last;
    int         stall;
    logic [7:0] mask;
    logic       hok;
    mask = 8'h00; last = -1; ex = N + 50; dn = N + 50; p = 1'b0; c = 3'd0;
    for (int k = 0; k < N; k++) begin
      stall = k - last - 1;
      hok   = st_mode ? (&(mask | st_h[k])) : (|st_h[k]);
      if (st_mon[k]) begin
        ex = k + 1; dn = k + 1 + DR_CYC; c = 3'd1; return;
      end else if (st_mem[k]) begin
        ex = k + 1; dn = k + 1 + DR_CYC; c = 3'd2; return;
      end else if (hok) begin
        ex = k + 1; dn = k + 1; p = 1'b1; return;
      end else if (k + 1 >= TO_CYC) begin
        ex = k + 1; dn = k + 1; c = 3'd3; return;
      end else if (stall + 1 >= ST_CYC) begin
        ex = k + 1; dn = k + 1; c = 3'd4; return;
      end
      mask = mask | st_h[k];
      if (st_c[k] != 8'h00) last = k;
    end
  endtask

  // Apply the stimulus arrays from the first RUN cycle and check each edge.
  task automatic run_case(input int ex, input int dn, input logic p, input logic [2:0] c);
    halt_mode = st_mode;
    for (int s = 0; s < N; s++) begin
      halt = st_h[s]; commit = st_c[s]; mon_error = st_mon[s]; mem_error = st_mem[s];
      step();
      chk("done", 64'(done), 64'((s + 1 >= dn) ? 1 : 0));
      chk("running", 64'(running), 64'((s + 1 < ex) ? 1 : 0));
      chk("cycle_count", 64'(cycle_count), 64'((s + 1 < ex) ? s + 1 : ex));
    end
    clear_inputs();
    chk("final_done", 64'(done), 64'd1);
    chk("final_pass", 64'(pass), 64'(p));
    chk("final_fail_code", 64'(fail_code), 64'(c));
    chk("final_cycle_count", 64'(cycle_count), 64'(ex));
    chk("final_dut_rst", 64'(dut_rst), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rp;
    logic [2:0] rc;
    int         rex;
    int         rdn;
    int         pc;
    n_cmp = 0; n_mis = 0; cur_case = 0;
    rst = 1'b0;
    clear_inputs();

    // mode, h1@, h1, h2@, h2, mon@, mem@, last commit, exit, done, pass, code
    vecs[0]  = '{1'b0, 50, 8'h20, -1, 8'h00, -1, -1, 1000, 51, 51, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, 10, 8'h01, 30, 8'hFE, -1, -1, 1000, 31, 31, 1'b1, 3'd0};
    vecs[2]  = '{1'b1, 10, 8'h01, 30, 8'h7E, -1, -1, 1000, 100, 100, 1'b0, 3'd3};
    vecs[3]  = '{1'b0, 41, 8'h01, -1, 8'h00, -1, 40, 1000, 41, 46, 1'b0, 3'd2};
    vecs[4]  = '{1'b0, -1, 8'h00, -1, 8'h00, 25, 25, 1000, 26, 31, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, -1, 8'h00, -1, 8'h00, -1, -1, 1000, 100, 100, 1'b0, 3'd3};
    vecs[6]  = '{1'b0, -1, 8'h00, -1, 8'h00, -1, -1, 20, 37, 37, 1'b0, 3'd4};
    vecs[7]  = '{1'b0, 99, 8'h80, -1, 8'h00, -1, -1, 1000, 100, 100, 1'b1, 3'd0};
    vecs[8]  = '{1'b0, 0, 8'h01, -1, 8'h00, -1, -1, 1000, 1, 1, 1'b1, 3'd0};
    vecs[9]  = '{1'b1, 12, 8'hFF, -1, 8'h00, 12, -1, 1000, 13, 18, 1'b0, 3'd1};
    vecs[10] = '{1'b0, -1, 8'h00, -1, 8'h00, -1, -1, 5, 22, 22, 1'b0, 3'd4};
    vecs[11] = '{1'b1, 5, 8'h0F, 60, 8'hF0, -1, -1, 40, 57, 57, 1'b0, 3'd4};

    for (int i = 0; i < NV; i++) begin
      cur_case = i;
      do_reset();
      fill_from_vec(vecs[i]);
      run_case(vecs[i].exit_step, vecs[i].done_step, vecs[i].exp_pass, vecs[i].exp_code);
    end

    // Reset during DRAIN, then a fresh run that passes.
    cur_case = 100;
    do_reset();
    commit = 8'hFF;
    step(); step(); step();
    mem_error = 1'b1;
    step();
    mem_error = 1'b0;
    step();
    chk("drain_running", 64'(running), 64'd0);
    chk("drain_done", 64'(done), 64'd0);
    chk("drain_fail_code", 64'(fail_code), 64'd2);
    chk("drain_cycle_count", 64'(cycle_count), 64'd4);
    rst = 1'b0;
    step();
    chk_reset_vals();
    do_reset();
    for (int k = 0; k < N; k++) begin
      st_h[k] = (k == 5) ? 8'h01 : 8'h00; st_c[k] = 8'hFF; st_mon[k] = 1'b0; st_mem[k] = 1'b0;
    end
    st_mode = 1'b0;
    run_case(6, 6, 1'b1, 3'd0);

    // Random runs against the verdict model.
    for (int r = 0; r < 8; r++) begin
      cur_case = 200 + r;
      st_mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       pc = 100;
        1:       pc = 95;
        2:       pc = 60;
        default: pc = 10;
      endcase
      for (int k = 0; k < N; k++) begin
        st_c[k] = ($urandom_range(0, 99) < pc) ? 8'($urandom) : 8'h00;
        if (st_mode)
          st_h[k] = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        else
          st_h[k] = ($urandom_range(0, 59) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        st_mon[k] = ($urandom_range(0, 199) == 0);
        st_mem[k] = ($urandom_range(0, 199) == 0);
      end
      model(rex, rdn, rp, rc);
      do_reset();
      run_case(rex, rdn, rp, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
